// File: rtl/sm3_msg_expnd.sv
// rtl/sm3_msg_expnd.sv - SM3 message expansion: loads 16 words, emits (W_j, W'_j) per round
module sm3_msg_expnd #(
  parameter int ROUNDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        msg_vld,
  input  logic [31:0] msg_word,
  output logic        msg_rdy,
  output logic        out_vld,
  input  logic        out_rdy,
  output logic [31:0] out_w,
  output logic [31:0] out_wp,
  output logic [5:0]  out_idx,
  output logic        out_lst
);

  typedef enum logic {LOAD, EXPAND} state_t;

  state_t      state;
  logic [31:0] win [16];
  logic [5:0]  cnt;
  logic        rdy_q;
  logic        vld_q;
  logic        last;
  logic [31:0] p1_in;
  logic [31:0] p1_out;
  logic [31:0] nxt_w;

  assign last = (cnt == 6'(ROUNDS - 1));

  // W_{j+16} from the window holding W_j..W_{j+15}; fixed rotates are pure wiring
  always_comb begin
    p1_in  = win[0] ^ win[7] ^ {win[13][16:0], win[13][31:17]};
    p1_out = p1_in ^ {p1_in[16:0], p1_in[31:17]} ^ {p1_in[8:0], p1_in[31:9]};
    nxt_w  = p1_out ^ {win[3][24:0], win[3][31:25]} ^ win[10];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
      cnt   <= '0;
      rdy_q <= 1'b0;
      vld_q <= 1'b0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else begin
      case (state)
        LOAD: begin
          rdy_q <= 1'b1;
          if (msg_vld && rdy_q) begin
            for (int i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15] <= msg_word;
            if (cnt == 6'd15) begin
              cnt   <= '0;
              state <= EXPAND;
              rdy_q <= 1'b0;
              vld_q <= 1'b1;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        EXPAND: begin
          if (out_rdy) begin
            for (int i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15] <= nxt_w;
            if (last) begin
              cnt   <= '0;
              state <= LOAD;
              rdy_q <= 1'b1;
              vld_q <= 1'b0;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Outputs are forced to zero outside EXPAND so stale window data never leaks
  assign msg_rdy = rdy_q;
  assign out_vld = vld_q;
  assign out_w   = vld_q ? win[0] : '0;
  assign out_wp  = vld_q ? (win[0] ^ win[4]) : '0;
  assign out_idx = vld_q ? cnt : '0;
  assign out_lst = vld_q & last;

endmodule

// File: tb/tb_sm3_msg_expnd.sv
// tb/tb_sm3_msg_expnd.sv - self-checking bench for sm3_msg_expnd against an array-based SM3 model
module tb_sm3_msg_expnd;

  localparam int ROUNDS = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        msg_vld;
  logic [31:0] msg_word;
  logic        msg_rdy;
  logic        out_vld;
  logic        out_rdy;
  logic [31:0] out_w;
  logic [31:0] out_wp;
  logic [5:0]  out_idx;
  logic        out_lst;

  sm3_msg_expnd #(.ROUNDS(ROUNDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .msg_vld(msg_vld), .msg_word(msg_word), .msg_rdy(msg_rdy),
    .out_vld(out_vld), .out_rdy(out_rdy),
    .out_w(out_w), .out_wp(out_wp), .out_idx(out_idx), .out_lst(out_lst)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mw [68];
  logic [31:0] got_w [64];
  logic [31:0] got_wp [64];
  logic [31:0] abc [16];
  logic [31:0] blk [16];

  typedef struct {
    int          idx;
    logic [31:0] w;
    logic [31:0] wp;
    bit          chk_wp;
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rol(x, 15) ^ rol(x, 23);
  endfunction

  task automatic build_model(input logic [31:0] b [16]);
    for (int i = 0; i < 16; i++) mw[i] = b[i];
    for (int j = 16; j < 68; j++)
      mw[j] = p1(mw[j-16] ^ mw[j-9] ^ rol(mw[j-3], 15)) ^ rol(mw[j-13], 7) ^ mw[j-6];
  endtask

  // Entered and left at a negedge; returns the cycle stamp of the first word's handshake.
  task automatic load_block(input logic [31:0] b [16], input int maxgap, output int start);
    int guard;
    start = -1;
    for (int k = 0; k < 16; k++) begin
      repeat ($urandom_range(0, maxgap)) begin
        msg_vld = 1'b0;
        @(negedge clk);
      end
      msg_vld  = 1'b1;
      msg_word = b[k];
      guard = 0;
      while (!msg_rdy && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (!msg_rdy) begin
        chk("load_timeout", 32'(k), 32'hffff_ffff);
        msg_vld = 1'b0;
        return;
      end
      if (k == 0) start = cyc;
      @(negedge clk);
    end
    msg_vld = 1'b0;
  endtask

  // Drains pairs up to stop_at, checking each against the model and stall stability.
  task automatic collect(input int stall_pct, input bit junk, input int stop_at, input bit capture);
    int k, guard;
    bit held;
    logic [31:0] hw, hwp;
    logic [5:0]  hidx;
    k = 0; guard = 0; held = 0; hw = '0; hwp = '0; hidx = '0;
    chk("first_vld", 32'(out_vld), 32'd1);
    chk("rdy_low_in_expand", 32'(msg_rdy), 32'd0);
    while (k < stop_at && guard < 5000) begin
      out_rdy = ($urandom_range(0, 99) >= stall_pct);
      if (junk) begin
        msg_vld  = 1'b1;
        msg_word = $urandom;
      end
      if (!out_vld) begin
        chk("vld_dropped", 32'(out_vld), 32'd1);
        break;
      end
      if (held) begin
        chk("stall_w", out_w, hw);
        chk("stall_wp", out_wp, hwp);
        chk("stall_idx", 32'(out_idx), 32'(hidx));
      end
      if (out_rdy) begin
        chk($sformatf("w[%0d]", k), out_w, mw[k]);
        chk($sformatf("wp[%0d]", k), out_wp, mw[k] ^ mw[k+4]);
        chk($sformatf("idx[%0d]", k), 32'(out_idx), 32'(k));
        chk($sformatf("lst[%0d]", k), 32'(out_lst), 32'(k == ROUNDS - 1));
        if (capture) begin
          got_w[k]  = out_w;
          got_wp[k] = out_wp;
        end
        k++;
        held = 0;
      end else begin
        held = 1; hw = out_w; hwp = out_wp; hidx = out_idx;
      end
      @(negedge clk);
      guard++;
    end
    if (k < stop_at) chk("collect_timeout", 32'(k), 32'(stop_at));
    out_rdy = 1'b0;
    msg_vld = 1'b0;
    if (stop_at == ROUNDS) begin
      chk("rdy_after_last", 32'(msg_rdy), 32'd1);
      chk("vld_after_last", 32'(out_vld), 32'd0);
    end
  endtask

  task automatic check_table(input string tag);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("%s_tbl_w%0d", tag, vecs[i].idx), got_w[vecs[i].idx], vecs[i].w);
      if (vecs[i].chk_wp)
        chk($sformatf("%s_tbl_wp%0d", tag, vecs[i].idx), got_wp[vecs[i].idx], vecs[i].wp);
    end
  endtask

  initial begin
    int s1, s2;
    vecs[0] = '{0,  32'h61626380, 32'h61626380, 1'b1};
    vecs[1] = '{16, 32'h9092e200, 32'h0,        1'b0};
    vecs[2] = '{17, 32'h00000000, 32'h0,        1'b0};
    vecs[3] = '{18, 32'h000c0606, 32'h0,        1'b0};
    vecs[4] = '{19, 32'h719c70ed, 32'h0,        1'b0};
    for (int i = 0; i < 16; i++) abc[i] = '0;
    abc[0]  = 32'h61626380;
    abc[15] = 32'h00000018;

    rst_n = 1'b0; msg_vld = 1'b0; msg_word = '0; out_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_msg_rdy", 32'(msg_rdy), 32'd0);
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_out_w", out_w, 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    rst_n = 1'b1;
    #1 chk("rdy_before_edge", 32'(msg_rdy), 32'd0);
    @(negedge clk);
    chk("rdy_after_release", 32'(msg_rdy), 32'd1);

    // "abc" block, no backpressure
    build_model(abc);
    load_block(abc, 0, s1);
    collect(0, 0, ROUNDS, 1);
    check_table("abc");

    // same block under ~50% backpressure
    load_block(abc, 0, s1);
    collect(50, 0, ROUNDS, 0);

    // junk on msg_vld during expansion, then a random block
    load_block(abc, 0, s1);
    collect(20, 1, ROUNDS, 0);
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    build_model(blk);
    load_block(blk, 0, s1);
    collect(30, 0, ROUNDS, 0);

    // async reset mid-expansion
    build_model(abc);
    load_block(abc, 0, s1);
    collect(0, 0, 20, 0);
    chk("pre_rst_idx", 32'(out_idx), 32'd20);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(out_vld), 32'd0);
    chk("mid_rst_rdy", 32'(msg_rdy), 32'd0);
    chk("mid_rst_w", out_w, 32'd0);
    chk("mid_rst_wp", out_wp, 32'd0);
    chk("mid_rst_idx", 32'(out_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin got_w[i] = 'x; got_wp[i] = 'x; end
    load_block(abc, 0, s1);
    collect(0, 0, ROUNDS, 1);
    check_table("post_rst");

    // back-to-back random blocks with input gaps
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 16; i++) blk[i] = $urandom;
      build_model(blk);
      load_block(blk, 3, s1);
      collect(25, 0, ROUNDS, 0);
    end

    // gapless back-to-back: block period
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    build_model(blk);
    load_block(blk, 0, s1);
    collect(0, 0, ROUNDS, 0);
    load_block(blk, 0, s2);
    chk("block_period", 32'(s2 - s1), 32'd80);
    collect(0, 0, ROUNDS, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/sm3_msg_expnd.md
Name: sm3_msg_expnd

Overview:
- Message-expansion stage of the SM3 core; sits directly upstream of the compression round datapath and its 3-input adders.
- Accepts one 512-bit message block as 16 big-endian 32-bit words on a valid/ready handshake.
- Emits one (W_j, W'_j) pair per round, j = 0..ROUNDS-1, on a valid/ready handshake with backpressure.
- The compression stage consumes one pair per round it executes.

Parameters:
- ROUNDS, 64, number of (W_j, W'_j) pairs emitted per block. Legal range 1..64; 64 for SM3 compliance, smaller values for debug only.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous assert, active-low.
- msg_vld  input  1  msg_word is valid.
- msg_word  input  32  message word; first word is W_0.
- msg_rdy  output  1  block can accept a message word.
- out_vld  output  1  out_w, out_wp and out_idx are valid.
- out_rdy  input  1  downstream accepts the current pair.
- out_w  output  32  W_j.
- out_wp  output  32  W'_j = W_j ^ W_{j+4}.
- out_idx  output  6  round index j.
- out_lst  output  1  high with the pair j = ROUNDS-1.

Behaviour:
- Reset (rst_n=0, async): state=LOAD, word/round counter=0, window registers=0.
- Outputs while in reset: msg_rdy=0, out_vld=0, out_w=0, out_wp=0, out_idx=0, out_lst=0.
- msg_rdy goes high on the first clk edge after rst_n deasserts.
- Storage: a 16-entry x 32-bit shift window win[0..15]; win[0] is the oldest word.
- State LOAD:
  - msg_rdy=1, out_vld=0.
  - Each cycle with msg_vld&msg_rdy: shift msg_word into win[15] (win[i] <= win[i+1]) and increment the counter.
  - On the 16th accepted word: counter <= 0, go to EXPAND. msg_rdy is 0 from the next cycle.
- State EXPAND:
  - msg_rdy=0, out_vld=1.
  - Outputs are combinational from registers: out_w=win[0], out_wp=win[0]^win[4], out_idx=counter, out_lst=(counter==ROUNDS-1).
  - Each cycle with out_vld&out_rdy: shift the window and load win[15] <= P1(win[0]^win[7]^(win[13]<<<15)) ^ (win[3]<<<7) ^ win[10], where P1(x)=x^(x<<<15)^(x<<<23) and <<< is 32-bit rotate left.
  - On that same handshake, counter increments.
  - Handshake with out_lst=1: go to LOAD with counter=0. msg_rdy=1 on the next cycle.
  - out_rdy=0: hold all outputs stable; window and counter unchanged.
- Latency and throughput:
  - First pair is valid the cycle after the 16th word is accepted.
  - One pair per cycle when out_rdy=1.
  - Block period is 16+ROUNDS cycles minimum. No overlap between loading and expansion.
- Boundary conditions:
  - msg_vld while in EXPAND: ignored, because msg_rdy=0. Upstream must hold the word.
  - msg_vld gaps in LOAD: the counter simply waits.
  - No partial-block flush exists.
  - Expansion words beyond W_67 may be computed into the window but are never emitted.
  - An asynchronous reset mid-load or mid-expansion discards the block and returns all state and outputs to reset values.

Test Plan:
- "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), out_rdy=1 -> pair j=0: out_w=0x61626380, out_wp=0x61626380. Pair j=16: out_w=0x9092e200. Pair j=17: out_w=0x00000000. Pair j=18: out_w=0x000c0606. Pair j=19: out_w=0x719c70ed.
- Same block: all 64 out_w/out_wp values match the software model; out_lst is high only at out_idx=63; msg_rdy returns high exactly 1 cycle after the final handshake.
- Random out_rdy deassertion (~50%) during EXPAND -> outputs stable while stalled; the emitted sequence is identical to the unstalled run; no pair is dropped or duplicated.
- msg_vld held high during EXPAND with changing msg_word -> no word captured; next block loads correctly after out_lst.
- rst_n pulsed low at out_idx=20 -> outputs are 0 and msg_rdy=0 asynchronously; after release, a fresh "abc" block reproduces the first test's values.
- Back-to-back blocks with msg_vld gaps of 0..3 cycles -> each block yields 64 correct pairs; 80-cycle block period when there are no gaps.
